// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared constants for the round-robin arbiter slice
package arb_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_GRANT = 1'b1;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

endpackage

// File: rtl/rr_arb4_enc_if.sv
// rtl/rr_arb4_enc_if.sv - request/grant bundle between requesters and the arbiter
interface rr_arb4_enc_if;
    import arb_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic               done;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_en;
    logic               timeout;
    logic               busy;

    // Requester side: raises requests and signals completion
    modport master (
        output req,
        output done,
        input  gnt_idx,
        input  gnt_en,
        input  timeout,
        input  busy
    );

    // Arbiter side: consumes requests, produces the encoded grant
    modport slave (
        input  req,
        input  done,
        output gnt_idx,
        output gnt_en,
        output timeout,
        output busy
    );

endinterface

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - rotating priority pick: first set request after last_ptr
module rr_pick4
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_ptr,
    output logic               any,
    output logic [IDX_W-1:0]   idx
);

    logic [IDX_W-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest set bit after
    // last_ptr wins; offset 4 wraps back onto last_ptr, the lowest priority.
    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = last_ptr + IDX_W'(i);
            if (req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/rr_arb4_enc.sv
// rtl/rr_arb4_enc.sv - four-way round-robin arbiter with encoded, held grant
module rr_arb4_enc
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    rr_arb4_enc_if.slave  bus
);

    localparam int CNT_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    logic             state_q,    state_d;
    logic [IDX_W-1:0] last_ptr_q, last_ptr_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [IDX_W-1:0] gnt_idx_q,  gnt_idx_d;
    logic             gnt_en_q,   gnt_en_d;
    logic             timeout_q,  timeout_d;

    logic             pick_any;
    logic [IDX_W-1:0] pick_idx;

    rr_pick4 u_pick (
        .req      (bus.req),
        .last_ptr (last_ptr_q),
        .any      (pick_any),
        .idx      (pick_idx)
    );

    // Next-state: arbitrate from IDLE only, so every handover has an idle gap
    always_comb begin
        state_d    = state_q;
        last_ptr_d = last_ptr_q;
        hold_cnt_d = hold_cnt_q;
        gnt_idx_d  = gnt_idx_q;
        gnt_en_d   = gnt_en_q;
        timeout_d  = 1'b0;
        if (state_q == ST_IDLE) begin
            gnt_en_d = 1'b0;
            if (pick_any) begin
                gnt_idx_d  = pick_idx;
                gnt_en_d   = 1'b1;
                hold_cnt_d = '0;
                state_d    = ST_GRANT;
            end
        end else begin
            // done / dropped request outrank the hold limit, so no timeout then
            if (bus.done || !bus.req[gnt_idx_q]) begin
                gnt_en_d   = 1'b0;
                state_d    = ST_IDLE;
                last_ptr_d = gnt_idx_q;
                hold_cnt_d = '0;
            end else if (MAX_HOLD != 0 && hold_cnt_q == HOLD_LAST) begin
                gnt_en_d   = 1'b0;
                state_d    = ST_IDLE;
                last_ptr_d = gnt_idx_q;
                hold_cnt_d = '0;
                timeout_d  = 1'b1;
            end else begin
                hold_cnt_d = hold_cnt_q + CNT_W'(1);
            end
        end
    end

    // State and output registers; last_ptr resets to 3 so requester 0 leads
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            last_ptr_q <= IDX_W'(NUM_REQ - 1);
            hold_cnt_q <= '0;
            gnt_idx_q  <= '0;
            gnt_en_q   <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_ptr_q <= last_ptr_d;
            hold_cnt_q <= hold_cnt_d;
            gnt_idx_q  <= gnt_idx_d;
            gnt_en_q   <= gnt_en_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.gnt_idx = gnt_idx_q;
    assign bus.gnt_en  = gnt_en_q;
    assign bus.timeout = timeout_q;
    assign bus.busy    = gnt_en_q;

endmodule

// File: doc/rr_arb4_enc.md
Name: rr_arb4_enc

Overview:
- Four-requester round-robin arbiter that sits directly upstream of the 2-to-4 decoder.
- Produces a registered 2-bit grant index (gnt_idx) and a grant enable (gnt_en), which drive the decoder's in/en inputs; the decoder then regenerates the one-hot grant.
- Holds each grant until the requester finishes, drops its request, or a hold timeout expires.
- Inserts one idle cycle between grants, so the decoder output is all-zero between owners.

Parameters:
- MAX_HOLD, 16: maximum cycles a grant may be held. 0 disables the timeout.
- CNT_W, $clog2(MAX_HOLD+1) (minimum 1): hold counter width. Derived; do not override.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low, sampled on rising clk
- req  input  4  request vector; bit i = requester i
- done  input  1  single-cycle pulse from the current owner: transfer finished
- gnt_idx  output  2  encoded index of the granted requester (drives decoder in)
- gnt_en  output  1  grant valid (drives decoder en)
- timeout  output  1  one-cycle pulse when a grant is revoked by the hold limit
- busy  output  1  high while in state GRANT (equals gnt_en)

Behaviour:
- All outputs are registered. No combinational path from inputs to outputs.
- Reset (rst_n=0 at a rising edge):
  - gnt_idx=2'b00, gnt_en=0, timeout=0, busy=0.
  - state=IDLE, last_ptr=2'b11 (so requester 0 has top priority first), hold_cnt=0.
- States: IDLE, GRANT.
- IDLE:
  - If req != 0, select the first set bit searching last_ptr+1, last_ptr+2, ... modulo 4.
  - Next cycle: gnt_idx = selected index, gnt_en=1, hold_cnt=0, state=GRANT.
  - If req == 0, stay in IDLE; gnt_en=0 and gnt_idx holds its previous value.
- Latency: req asserted before edge N gives gnt_en=1 after edge N (one cycle).
- GRANT, checked in priority order each cycle:
  1. done=1, or req[gnt_idx]=0 → release.
  2. MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1 → release and pulse timeout=1 for one cycle.
  3. Otherwise hold_cnt increments by 1 and gnt_idx/gnt_en are held stable.
- Release:
  - Next cycle: gnt_en=0, state=IDLE, last_ptr=gnt_idx, hold_cnt=0.
  - gnt_idx keeps its value (it is don't-care while gnt_en=0).
- Arbitration restarts only from IDLE, giving a mandatory one-cycle gap between grants. Back-to-back throughput is therefore at most one grant per 2 cycles.
- Simultaneous events:
  - done and timeout condition in the same cycle: treat as a done release; timeout stays 0.
  - done while in IDLE: ignored.
  - req bits for non-owners changing during GRANT: ignored until IDLE.
- MAX_HOLD=1: every grant lasts exactly one cycle unless released earlier. A timeout pulse follows every grant that is not released by done or by the request dropping.
- Fairness: after owner k releases, requester k has lowest priority in the next arbitration.
- Reset mid-grant: at the next edge with rst_n=0, all state returns to reset values and gnt_en=0 immediately. No timeout pulse is produced.
- hold_cnt never exceeds MAX_HOLD-1; it saturates logically because release occurs first.

Decomposition:
- Shared package arb_pkg holds:
  - state encoding localparams ST_IDLE=1'b0, ST_GRANT=1'b1;
  - constant NUM_REQ=4;
  - IDX_W=2.
- One sub-module is natural: rr_pick4 (combinational). Inputs req[3:0] and last_ptr[1:0]; outputs any and idx[1:0]. It implements the rotate, priority-encode and un-rotate. Everything else (FSM, hold counter, output registers) stays in rr_arb4_enc.

Test Plan:
1. Reset, then req=4'b0001 held, done pulsed 3 cycles after grant → gnt_en=1 with gnt_idx=0 one cycle after req; gnt_en=0 the cycle after done; busy tracks gnt_en.
2. req=4'b1111 held, done pulsed 1 cycle into each grant → grant order 0,1,2,3,0 with exactly one gnt_en=0 cycle between grants.
3. MAX_HOLD=16, req=4'b0100 held, no done → gnt_idx=2 for exactly 16 cycles; timeout=1 for one cycle coincident with gnt_en falling; re-grant to 2 two cycles later.
4. Owner drops request: req=4'b0110, grant to 1, then req becomes 4'b0100 → release next cycle, then grant to 2; timeout stays 0.
5. done and hold limit coincide (done pulsed on cycle 16 of a hold) → release occurs, timeout remains 0.
6. rst_n=0 for one cycle mid-grant (gnt_idx=3) → next cycle gnt_en=0, gnt_idx=0, timeout=0; with req=4'b1000 still asserted, the grant returns to 3 one cycle after rst_n=1.
